// File: rtl/product_accumulator.sv
// ============================================================================
//  Module      : product_accumulator
//  Description : Sums groups of up to COUNT unsigned products and presents each
//                group sum on a valid/ready output. Build option ACC_SATURATE_EN
//                clamps the accumulator on carry instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module product_accumulator #(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 24,
    parameter int COUNT     = 4
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [IN_WIDTH-1:0]          i_product,
    input  logic                         i_last,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [ACC_WIDTH-1:0]         o_sum,
    output logic [$clog2(COUNT+1)-1:0]   o_count,
    output logic                         o_overflow
);

    localparam int                 CNT_W       = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0]   c_cnt_last  = CNT_W'(COUNT - 1);
    localparam logic [CNT_W-1:0]   c_cnt_one   = CNT_W'(1);

    typedef enum logic [0:0] {
        S_ACCUM = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [ACC_WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_ovf;

    logic [ACC_WIDTH:0]     w_prod_ext;
    logic [ACC_WIDTH:0]     w_sum;
    logic                   w_carry;
    logic [ACC_WIDTH-1:0]   w_acc_next;
    logic                   w_ovf_next;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   w_beat;
    logic                   w_close;
    logic                   w_out_xfer;

    // Handshakes decoded from the state register so the ready path has no loop
    assign w_beat     = i_valid & (r_state == S_ACCUM);
    assign w_close    = w_beat & ((r_cnt == c_cnt_last) | i_last);
    assign w_out_xfer = (r_state == S_HOLD) & i_ready;

    assign w_prod_ext = {{(ACC_WIDTH + 1 - IN_WIDTH){1'b0}}, i_product};
    assign w_sum      = {1'b0, r_acc} + w_prod_ext;
    assign w_carry    = w_sum[ACC_WIDTH];
    assign w_ovf_next = r_ovf | w_carry;
    assign w_cnt_next = r_cnt + c_cnt_one;

`ifdef ACC_SATURATE_EN
    // Once clamped, the accumulator stays at full scale until the group ends
    assign w_acc_next = w_ovf_next ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
`else
    assign w_acc_next = w_sum[ACC_WIDTH-1:0];
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_ready      = 1'b0;
        o_valid      = 1'b0;
        case (r_state)
            S_ACCUM: begin
                o_ready = 1'b1;
                if (w_close) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    w_state_next = S_ACCUM;
                end
            end
            default: begin
                w_state_next = S_ACCUM;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            o_sum      <= '0;
            o_count    <= '0;
            o_overflow <= 1'b0;
        end else if (w_beat) begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_next;
            r_ovf <= w_ovf_next;
            if (w_close) begin
                o_sum      <= w_acc_next;
                o_count    <= w_cnt_next;
                o_overflow <= w_ovf_next;
            end
        end else if (w_out_xfer) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_product_accumulator.sv
// ============================================================================
//  Module      : tb_product_accumulator
//  Description : Self-checking bench for product_accumulator with a group-level
//                reference model; honours ACC_SATURATE_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_product_accumulator;

    localparam int ACC_W = 24;
    localparam int CNT   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // main instance: defaults
    logic        valid, ready_o, last, vld_o, rdy_i, ovf;
    logic [15:0] product;
    logic [23:0] sum;
    logic [2:0]  count;

    // instance 2: ACC_WIDTH=16, COUNT=2
    logic        v2, r2o, l2, vo2, ri2, ovf2;
    logic [15:0] p2, s2;
    logic [1:0]  c2;

    // instance 3: COUNT=1
    logic        v3, r3o, l3, vo3, ri3, ovf3;
    logic [15:0] p3;
    logic [23:0] s3;
    logic [0:0]  c3;

    product_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(24), .COUNT(4)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .o_ready(ready_o),
        .i_product(product), .i_last(last), .o_valid(vld_o), .i_ready(rdy_i),
        .o_sum(sum), .o_count(count), .o_overflow(ovf));

    product_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(16), .COUNT(2)) dut2 (
        .i_clk(clk), .i_reset(rst), .i_valid(v2), .o_ready(r2o),
        .i_product(p2), .i_last(l2), .o_valid(vo2), .i_ready(ri2),
        .o_sum(s2), .o_count(c2), .o_overflow(ovf2));

    product_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(24), .COUNT(1)) dut3 (
        .i_clk(clk), .i_reset(rst), .i_valid(v3), .o_ready(r3o),
        .i_product(p3), .i_last(l3), .o_valid(vo3), .i_ready(ri3),
        .o_sum(s3), .o_count(c3), .o_overflow(ovf3));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Group-level reference: sum of the accepted products, judged against 2^ACC_W
    function automatic logic [ACC_W-1:0] model_sum(input longint total);
`ifdef ACC_SATURATE_EN
        if (total >= (longint'(1) << ACC_W)) return '1;
`endif
        return total[ACC_W-1:0];
    endfunction

    logic           m_known = 1'b0;
    logic           m_hold;
    longint         m_total;
    int             m_n;
    logic [23:0]    m_sum;
    int             m_cnt;
    logic           m_ovf;
    int             m_groups = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_known <= 1'b1;
            m_hold  <= 1'b0;
            m_total <= 0;
            m_n     <= 0;
        end else if (m_known && !m_hold) begin
            if (valid) begin
                m_total <= m_total + longint'(product);
                m_n     <= m_n + 1;
                if (m_n + 1 == CNT || last) begin
                    m_hold <= 1'b1;
                    m_sum  <= model_sum(m_total + longint'(product));
                    m_cnt  <= m_n + 1;
                    m_ovf  <= (m_total + longint'(product)) >= (longint'(1) << ACC_W);
                end
            end
        end else if (m_known && rdy_i) begin
            m_hold   <= 1'b0;
            m_total  <= 0;
            m_n      <= 0;
            m_groups <= m_groups + 1;
        end
    end

    always @(negedge clk) begin
        if (m_known && !rst) begin
            check("ready", 64'(ready_o), 64'(!m_hold));
            check("valid", 64'(vld_o), 64'(m_hold));
            if (m_hold) begin
                check("sum",      64'(sum),   64'(m_sum));
                check("count",    64'(count), 64'(m_cnt));
                check("overflow", 64'(ovf),   64'(m_ovf));
            end
        end
    end

    task automatic send(input logic [15:0] p, input logic l);
        int waited;
        waited  = 0;
        valid   = 1'b1;
        product = p;
        last    = l;
        @(posedge clk);
        while (m_hold && waited < 50) begin
            waited++;
            @(posedge clk);
        end
        if (waited >= 50) check("send_timeout", 64'd1, 64'd0);
        #1;
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic release_main();
        rdy_i = 1'b1;
        @(posedge clk);
        #1 rdy_i = 1'b0;
    endtask

    logic [15:0] t6_prods [10];
    logic        acc_now;

    initial begin
        rst = 1'b1;
        valid = 0; product = 0; last = 0; rdy_i = 0;
        v2 = 0; p2 = 0; l2 = 0; ri2 = 0;
        v3 = 0; p3 = 0; l3 = 0; ri3 = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_valid", 64'(vld_o),   64'd0);
        check("rst_sum",   64'(sum),     64'd0);
        check("rst_count", 64'(count),   64'd0);
        check("rst_ovf",   64'(ovf),     64'd0);
        check("rst_valid2", 64'(vo2),    64'd0);
        check("rst_ready3", 64'(r3o),    64'd1);
        @(posedge clk); #1;

        // T1 + T3: full group, then backpressure with an offered beat
        send(16'h03C0, 0); send(16'h03F0, 0); send(16'hFE01, 0); send(16'h0001, 0);
        check("t1_latency", 64'(vld_o), 64'd1);
        @(negedge clk);
        check("t1_sum",   64'(sum),   64'h0105B2);
        check("t1_count", 64'(count), 64'd4);
        check("t1_ovf",   64'(ovf),   64'd0);
        valid = 1'b1; product = 16'h7777; last = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t3_ready", 64'(ready_o), 64'd0);
            check("t3_sum",   64'(sum),     64'h0105B2);
        end
        valid = 1'b0; last = 1'b0;
        release_main();

        // T2: early close
        send(16'h03C0, 0); send(16'h03F0, 1);
        @(negedge clk);
        check("t2_sum",   64'(sum),   64'h0007B0);
        check("t2_count", 64'(count), 64'd2);
        release_main();

        // T5: reset mid-group discards the partial sum
        send(16'h1234, 0); send(16'h1111, 0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t5_no_out", 64'(vld_o), 64'd0);
        repeat (4) send(16'h0001, 0);
        @(negedge clk);
        check("t5_sum",   64'(sum),   64'h000004);
        check("t5_count", 64'(count), 64'd4);
        release_main();

        // T4: overflow on a 16-bit accumulator
        v2 = 1'b1; p2 = 16'hFFFF;
        @(posedge clk); #1 p2 = 16'h0002;
        @(posedge clk); #1 v2 = 1'b0;
        @(negedge clk);
        check("t4_valid", 64'(vo2), 64'd1);
`ifdef ACC_SATURATE_EN
        check("t4_sum", 64'(s2), 64'hFFFF);
`else
        check("t4_sum", 64'(s2), 64'h0001);
`endif
        check("t4_ovf",   64'(ovf2), 64'd1);
        check("t4_count", 64'(c2),   64'd2);
        ri2 = 1'b1; @(posedge clk); #1 ri2 = 1'b0;
        v2 = 1'b1; p2 = 16'h0001;
        @(posedge clk); #1 p2 = 16'h0002;
        @(posedge clk); #1 v2 = 1'b0;
        @(negedge clk);
        check("t4b_sum", 64'(s2),   64'h0003);
        check("t4b_ovf", 64'(ovf2), 64'd0);
        ri2 = 1'b1; @(posedge clk); #1 ri2 = 1'b0;

        // T6: COUNT=1, one sum every two cycles
        foreach (t6_prods[i]) t6_prods[i] = 16'($urandom);
        ri3 = 1'b1; v3 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            p3 = t6_prods[i];
            @(posedge clk); #1;
            check("t6_valid", 64'(vo3), 64'd1);
            check("t6_sum",   64'(s3),  64'(t6_prods[i]));
            check("t6_count", 64'(c3),  64'd1);
            if (i < 9) p3 = t6_prods[i+1];
            @(posedge clk); #1;
            check("t6_gap_valid", 64'(vo3), 64'd0);
            check("t6_gap_ready", 64'(r3o), 64'd1);
        end
        v3 = 1'b0; ri3 = 1'b0;

        // Randomized traffic with stable-while-stalled upstream
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            acc_now = valid && !m_hold && !rst;
            #1;
            rst = (c == 300);
            if (!valid || acc_now) begin
                valid   = ($urandom_range(0, 3) != 0);
                product = 16'($urandom);
                last    = ($urandom_range(0, 3) == 0);
            end
            rdy_i = ($urandom_range(0, 2) != 0);
        end
        valid = 1'b0; last = 1'b0; rdy_i = 1'b1; rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("groups_seen", 64'(m_groups > 20), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
